// File: rtl/rx_bitalign_seq_pkg.sv
// Shared types and widths for the receive bit-align lane training sequencer.
package rx_bitalign_seq_pkg;

    localparam int LANE_IDX_W = 3;
    localparam int RETRY_W    = 3;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK   = 3'd0,
        ST_IDLE        = 3'd1,
        ST_ARM         = 3'd2,
        ST_WAIT_ACK    = 3'd3,
        ST_WAIT_RESULT = 3'd4,
        ST_NEXT        = 3'd5,
        ST_COMPLETE    = 3'd6
    } state_t;

    function automatic logic is_busy_state(input state_t st);
        return (st == ST_ARM) || (st == ST_WAIT_ACK) ||
               (st == ST_WAIT_RESULT) || (st == ST_NEXT);
    endfunction

endpackage

// File: rtl/rx_bitalign_tmo_cnt.sv
// Per-phase timeout counter; expired is high in the cycle the count is all-ones.
module rx_bitalign_tmo_cnt #(
    parameter int TMO_WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMO_WIDTH-1:0] cnt_r;
    logic [TMO_WIDTH-1:0] cnt_nxt_s;
    logic                 expired_r;

    // Next count: clear wins over enable so a phase always starts from zero.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = {TMO_WIDTH{1'b0}};
        end else if (en) begin
            cnt_nxt_s = cnt_r + {{(TMO_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register and registered all-ones flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {TMO_WIDTH{1'b0}};
            expired_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            expired_r <= &cnt_nxt_s;
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/rx_bitalign_lane_seq.sv
// Training sequencer: releases one bit-align lane at a time, restarts it,
// watches for done/err/oor with bounded retries and reports lane status.
module rx_bitalign_lane_seq
    import rx_bitalign_seq_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int MAX_RETRY = 3,
    parameter int TMO_WIDTH = 16
) (
    input  logic                  SCLK,
    input  logic                  RESET,
    input  logic                  PLL_LOCK,
    input  logic                  TRNG_REQ,
    input  logic [NUM_LANES-1:0]  LANE_START,
    input  logic [NUM_LANES-1:0]  LANE_DONE_IN,
    input  logic [NUM_LANES-1:0]  LANE_ERR_IN,
    input  logic [NUM_LANES-1:0]  LANE_OOR_IN,
    output logic [NUM_LANES-1:0]  LANE_RSTRT,
    output logic [NUM_LANES-1:0]  LANE_HOLD,
    output logic [NUM_LANES-1:0]  LANE_OK,
    output logic [NUM_LANES-1:0]  LANE_FAIL,
    output logic [LANE_IDX_W-1:0] CUR_LANE,
    output logic                  BUSY,
    output logic                  ALL_DONE
);

    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(NUM_LANES - 1);
    localparam logic [LANE_IDX_W-1:0] LANE_ONE  = LANE_IDX_W'(1);
    localparam logic [RETRY_W-1:0]    RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0]    RETRY_ONE = RETRY_W'(1);

    state_t                  state_r, state_nxt_s, fail_state_s;
    logic [LANE_IDX_W-1:0]   lane_r, lane_nxt_s;
    logic [RETRY_W-1:0]      retry_r, retry_nxt_s, retry_fail_s;
    logic                    auto_r;
    logic [NUM_LANES-1:0]    lane_sel_s;
    logic [NUM_LANES-1:0]    hold_r, rstrt_r, ok_r, fail_r;
    logic                    busy_r, all_done_r;
    logic                    hit_start_s, hit_done_s, hit_bad_s, exhausted_s;
    logic                    start_seq_s, pass_s, fail_att_s;
    logic                    tmo_clr_s, tmo_en_s, tmo_exp_s;

    // One-hot select of the lane currently being trained.
    always_comb begin
        lane_sel_s = {NUM_LANES{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_sel_s[i] = (lane_r == LANE_IDX_W'(i));
        end
    end

    assign hit_start_s  = |(LANE_START & lane_sel_s);
    assign hit_done_s   = |(LANE_DONE_IN & lane_sel_s);
    assign hit_bad_s    = |((LANE_ERR_IN | LANE_OOR_IN) & lane_sel_s);
    assign exhausted_s  = (retry_r >= RETRY_MAX);
    assign fail_state_s = exhausted_s ? ST_NEXT : ST_ARM;
    assign retry_fail_s = exhausted_s ? retry_r : (retry_r + RETRY_ONE);

    // Sequencer next-state; ERR/OOR are checked ahead of DONE.
    always_comb begin
        state_nxt_s = state_r;
        lane_nxt_s  = lane_r;
        retry_nxt_s = retry_r;
        start_seq_s = 1'b0;
        pass_s      = 1'b0;
        fail_att_s  = 1'b0;
        if (!PLL_LOCK) begin
            state_nxt_s = ST_WAIT_LOCK;
            lane_nxt_s  = {LANE_IDX_W{1'b0}};
            retry_nxt_s = {RETRY_W{1'b0}};
        end else begin
            case (state_r)
                ST_WAIT_LOCK: state_nxt_s = ST_IDLE;
                ST_IDLE: begin
                    if (TRNG_REQ || auto_r) begin
                        start_seq_s = 1'b1;
                        state_nxt_s = ST_ARM;
                        lane_nxt_s  = {LANE_IDX_W{1'b0}};
                        retry_nxt_s = {RETRY_W{1'b0}};
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ARM: state_nxt_s = ST_WAIT_ACK;
                ST_WAIT_ACK: begin
                    if (hit_start_s) begin
                        state_nxt_s = ST_WAIT_RESULT;
                    end else if (tmo_exp_s) begin
                        fail_att_s  = 1'b1;
                        state_nxt_s = fail_state_s;
                        retry_nxt_s = retry_fail_s;
                    end else begin
                        state_nxt_s = ST_WAIT_ACK;
                    end
                end
                ST_WAIT_RESULT: begin
                    if (hit_bad_s || (!hit_done_s && tmo_exp_s)) begin
                        fail_att_s  = 1'b1;
                        state_nxt_s = fail_state_s;
                        retry_nxt_s = retry_fail_s;
                    end else if (hit_done_s) begin
                        pass_s      = 1'b1;
                        state_nxt_s = ST_NEXT;
                    end else begin
                        state_nxt_s = ST_WAIT_RESULT;
                    end
                end
                ST_NEXT: begin
                    if (lane_r == LAST_LANE) begin
                        state_nxt_s = ST_COMPLETE;
                    end else begin
                        state_nxt_s = ST_ARM;
                        lane_nxt_s  = lane_r + LANE_ONE;
                        retry_nxt_s = {RETRY_W{1'b0}};
                    end
                end
                ST_COMPLETE: state_nxt_s = ST_IDLE;
                default:     state_nxt_s = ST_WAIT_LOCK;
            endcase
        end
    end

    assign tmo_en_s  = (state_r == ST_WAIT_ACK) || (state_r == ST_WAIT_RESULT);
    assign tmo_clr_s = (state_nxt_s != state_r) &&
                       ((state_nxt_s == ST_WAIT_ACK) || (state_nxt_s == ST_WAIT_RESULT));

    rx_bitalign_tmo_cnt #(
        .TMO_WIDTH (TMO_WIDTH)
    ) u_tmo_cnt (
        .clk     (SCLK),
        .rst     (RESET),
        .clr     (tmo_clr_s),
        .en      (tmo_en_s),
        .expired (tmo_exp_s)
    );

    // State, lane/retry counters and registered lane controls/status.
    always_ff @(posedge SCLK) begin
        if (RESET) begin
            state_r    <= ST_WAIT_LOCK;
            lane_r     <= {LANE_IDX_W{1'b0}};
            retry_r    <= {RETRY_W{1'b0}};
            auto_r     <= 1'b0;
            hold_r     <= {NUM_LANES{1'b1}};
            rstrt_r    <= {NUM_LANES{1'b0}};
            ok_r       <= {NUM_LANES{1'b0}};
            fail_r     <= {NUM_LANES{1'b0}};
            busy_r     <= 1'b0;
            all_done_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            lane_r  <= lane_nxt_s;
            retry_r <= retry_nxt_s;
            busy_r  <= is_busy_state(state_nxt_s);
            rstrt_r <= {NUM_LANES{1'b0}};
            if (!PLL_LOCK) begin
                auto_r     <= 1'b0;
                hold_r     <= {NUM_LANES{1'b1}};
                ok_r       <= {NUM_LANES{1'b0}};
                fail_r     <= {NUM_LANES{1'b0}};
                all_done_r <= 1'b0;
            end else begin
                // Lock just (re)acquired: the first IDLE visit trains without a request.
                if (state_r == ST_WAIT_LOCK) begin
                    auto_r <= 1'b1;
                end
                if (start_seq_s) begin
                    auto_r     <= 1'b0;
                    ok_r       <= {NUM_LANES{1'b0}};
                    fail_r     <= {NUM_LANES{1'b0}};
                    all_done_r <= 1'b0;
                end
                if (state_r == ST_ARM) begin
                    rstrt_r <= lane_sel_s;
                    hold_r  <= ~lane_sel_s;
                end
                if (pass_s) begin
                    ok_r   <= ok_r | lane_sel_s;
                    hold_r <= {NUM_LANES{1'b1}};
                end
                if (fail_att_s) begin
                    hold_r <= {NUM_LANES{1'b1}};
                    if (exhausted_s) begin
                        fail_r <= fail_r | lane_sel_s;
                    end
                end
                if (state_r == ST_COMPLETE) begin
                    all_done_r <= &ok_r;
                end
            end
        end
    end

    assign LANE_RSTRT = rstrt_r;
    assign LANE_HOLD  = hold_r;
    assign LANE_OK    = ok_r;
    assign LANE_FAIL  = fail_r;
    assign CUR_LANE   = lane_r;
    assign BUSY       = busy_r;
    assign ALL_DONE   = all_done_r;

endmodule

// File: doc/rx_bitalign_lane_seq.md
# rx_bitalign_lane_seq

Training sequencer for the receive bit-alignment cores of a multi-lane video interface. It shares one training window among NUM_LANES bit-align instances: one lane at a time is released from hold, restarted, and watched for done, error or out-of-range. Failed lanes are retried a bounded number of times. Per-lane and aggregate status goes to the link/video control logic. The block sits between the PLL-lock/system control and the per-lane bit-align cores' RSTRT/HOLD/status pins.

## Interface
Parameters:
- NUM_LANES, 4, number of bit-align lanes sequenced (1..8)
- MAX_RETRY, 3, retries per lane after the first attempt (0..7)
- TMO_WIDTH, 16, width of the per-phase timeout counter; timeout at 2^TMO_WIDTH-1 cycles

Ports:
- SCLK  in  1  fabric clock; everything is synchronous to it
- RESET  in  1  reset, synchronous, active-high
- PLL_LOCK  in  1  receive PLL locked
- TRNG_REQ  in  1  one-cycle pulse; (re)train all lanes
- LANE_START  in  NUM_LANES  per-lane BIT_ALGN_START from the cores
- LANE_DONE_IN  in  NUM_LANES  per-lane BIT_ALGN_DONE
- LANE_ERR_IN  in  NUM_LANES  per-lane BIT_ALGN_ERR
- LANE_OOR_IN  in  NUM_LANES  per-lane BIT_ALGN_OOR
- LANE_RSTRT  out  NUM_LANES  per-lane BIT_ALGN_RSTRT, one-cycle pulse
- LANE_HOLD  out  NUM_LANES  per-lane BIT_ALGN_HOLD
- LANE_OK  out  NUM_LANES  lane trained successfully
- LANE_FAIL  out  NUM_LANES  lane exhausted its retries
- CUR_LANE  out  3  index of the lane being trained
- BUSY  out  1  sequence in progress
- ALL_DONE  out  1  sequence finished and every lane is OK

## Operation
- States: WAIT_LOCK, IDLE, ARM, WAIT_ACK, WAIT_RESULT, NEXT, COMPLETE.
- WAIT_LOCK: all HOLD=1. Go to IDLE when PLL_LOCK=1.
- IDLE: go to ARM with lane=0 and retry=0 on TRNG_REQ.
  - LANE_OK and LANE_FAIL are cleared on TRNG_REQ.
  - The first entry into IDLE after WAIT_LOCK behaves as an implicit TRNG_REQ (auto-train).
- ARM (1 cycle): HOLD[lane]=0, RSTRT[lane]=1; then go to WAIT_ACK.
- WAIT_ACK: wait for LANE_START[lane]=1, then go to WAIT_RESULT. A timeout is an attempt failure.
- WAIT_RESULT, checked in priority order:
  1. ERR or OOR = 1 → attempt failure.
  2. DONE = 1 → success: LANE_OK[lane]=1, HOLD[lane]=1, go to NEXT.
  3. Timeout → attempt failure.
- Attempt failure:
  - If retry < MAX_RETRY: retry += 1, HOLD[lane]=1, go to ARM.
  - Otherwise: LANE_FAIL[lane]=1, HOLD[lane]=1, go to NEXT.
- NEXT: if lane == NUM_LANES-1 go to COMPLETE; otherwise lane += 1, retry=0, go to ARM.
- COMPLETE: ALL_DONE = &LANE_OK. Go to IDLE on the next cycle; ALL_DONE is held until the next TRNG_REQ or lock loss.
- Only the current lane ever has HOLD=0. All others hold.
- PLL_LOCK=0 in any state → WAIT_LOCK next cycle:
  - all HOLD=1, RSTRT=0;
  - LANE_OK, LANE_FAIL and ALL_DONE cleared.
- TRNG_REQ while BUSY is ignored.
- BUSY=1 in ARM, WAIT_ACK, WAIT_RESULT and NEXT.

## Timing
- Reset values:
  - state=WAIT_LOCK;
  - LANE_HOLD all ones;
  - LANE_RSTRT, LANE_OK, LANE_FAIL, CUR_LANE, BUSY, ALL_DONE all 0.
- All outputs are registered.
- TRNG_REQ at cycle t (in IDLE) → RSTRT[0] high at t+2 (ARM entered at t+1 with registered outputs).
- Timeout counter:
  - cleared on every entry to WAIT_ACK/WAIT_RESULT;
  - increments once per cycle;
  - timeout fires the cycle the counter equals all-ones.
- DONE and ERR sampled in the same cycle: ERR wins.
- RESET takes priority over PLL_LOCK and all other inputs.
- Retry count is 3 bits and never exceeds MAX_RETRY.
- CUR_LANE is zero-extended to 3 bits.

## Structure
- Package rx_bitalign_seq_pkg:
  - state enum type;
  - LANE_IDX_W = 3;
  - RETRY_W = 3.
- One sub-module, rx_bitalign_tmo_cnt:
  - TMO_WIDTH-bit counter with clear/enable inputs and a registered `expired` output.
- FSM and per-lane status registers live in the top module.

## Test plan
- Auto-train: RESET, then PLL_LOCK=1. Each lane raises START 3 cycles after RSTRT and DONE 20 cycles later.
  - Expect RSTRT pulses in order lanes 0→3.
  - Expect LANE_OK=4'b1111, ALL_DONE=1, BUSY=0, HOLD all ones.
- Retry: lane 1 asserts ERR on its first two attempts, then DONE.
  - Expect three RSTRT pulses on lane 1.
  - Expect LANE_OK=4'b1111, LANE_FAIL=0.
- Exhaustion: lane 2 never asserts START, with TMO_WIDTH=4.
  - Expect 4 RSTRT pulses on lane 2, each 15 cycles apart plus overhead.
  - Expect LANE_FAIL=4'b0100, lane 3 still trained, ALL_DONE=0.
- Lock loss: drop PLL_LOCK mid WAIT_RESULT on lane 1.
  - Expect HOLD all ones and status cleared next cycle.
  - On relock, the sequence restarts at lane 0.
- Priority/ignore:
  - DONE and OOR high in the same cycle → counted as a failure.
  - TRNG_REQ pulsed while BUSY → no effect.
  - TRNG_REQ in IDLE → LANE_OK cleared and full retrain.
